// File: rtl/hsc_tdc_pkg.sv
// Shared FSM state encoding and width helpers for the TDC averaging block.
package hsc_tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int hw_width(input int taps);
        return $clog2(taps + 1);
    endfunction

    function automatic int acc_width(input int taps, input int log2_n);
        return hw_width(taps) + log2_n;
    endfunction

    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/hsc_popcount.sv
// Combinational Hamming weight of a W-bit vector; zero latency, no flow control.
module hsc_popcount #(
    parameter int W  = 64,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [OW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + OW'(vec[i]);
        end
    end

endmodule

// File: rtl/hsc_tdc_avg.sv
// TDC thermometer-code weight: 2-cycle stream pipeline, or 2^LOG2_N-sample average run.
// No backpressure: every val_in is taken; samples arriving outside an accumulating run are not summed.
module hsc_tdc_avg
    import hsc_tdc_pkg::*;
#(
    parameter int TAPS   = 64,
    parameter int NCH    = 2,
    parameter int LOG2_N = 4,
    localparam int HW_W  = hw_width(TAPS),
    localparam int ACC_W = acc_width(TAPS, LOG2_N),
    localparam int SEL_W = sel_width(NCH)
) (
    input  logic                clk_launch,
    input  logic                rst_n,
    input  logic [NCH*TAPS-1:0] taps_in,
    input  logic                val_in,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic                mode,
    input  logic                start,
    output logic [HW_W-1:0]     hw,
    output logic                val_out,
    output logic [HW_W-1:0]     hw_min,
    output logic [HW_W-1:0]     hw_max,
    output logic [ACC_W-1:0]    acc,
    output logic                busy,
    output logic                done
);

    state_t            state;
    logic [SEL_W-1:0]  ch_run;
    logic [SEL_W-1:0]  chan;
    logic [TAPS-1:0]   sel_taps;
    logic [TAPS-1:0]   tap_r;
    logic              s1;
    logic              a1;
    logic              a2;
    logic [HW_W-1:0]   weight;
    logic [HW_W-1:0]   w_r;
    logic [LOG2_N-1:0] cnt;
    logic              drain;

    // Run channel is frozen at start; out-of-range selects fall back to channel 0.
    assign chan = busy ? ch_run : ch_sel;

    always_comb begin
        sel_taps = taps_in[0 +: TAPS];
        for (int c = 1; c < NCH; c++) begin
            if (chan == SEL_W'(c)) begin
                sel_taps = taps_in[c*TAPS +: TAPS];
            end
        end
    end

    hsc_popcount #(.W(TAPS), .OW(HW_W)) u_popcount (
        .vec (tap_r),
        .cnt (weight)
    );

    assign hw = (state == DONE) ? acc[ACC_W-1:LOG2_N] : w_r;

    always_ff @(posedge clk_launch) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch_run  <= '0;
            tap_r   <= '0;
            s1      <= 1'b0;
            a1      <= 1'b0;
            a2      <= 1'b0;
            w_r     <= '0;
            val_out <= 1'b0;
            cnt     <= '0;
            drain   <= 1'b0;
            acc     <= '0;
            hw_min  <= HW_W'(TAPS);
            hw_max  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (val_in) begin
                tap_r <= sel_taps;
            end
            s1 <= val_in && !mode;
            a1 <= val_in && mode && (state == ACCUM);
            if (s1 || a1) begin
                w_r <= weight;
            end
            val_out <= s1;
            a2      <= a1;

            // Weights still in flight during DRAIN are summed before DONE is reached.
            if (a2 && busy && mode) begin
                acc <= acc + ACC_W'(w_r);
                if (w_r < hw_min) hw_min <= w_r;
                if (w_r > hw_max) hw_max <= w_r;
            end

            case (state)
                IDLE, DONE: begin
                    if (mode && start) begin
                        state  <= ACCUM;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        ch_run <= ch_sel;
                        acc    <= '0;
                        cnt    <= '0;
                        hw_min <= HW_W'(TAPS);
                        hw_max <= '0;
                    end
                end
                ACCUM: begin
                    if (!mode) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (val_in) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state <= DRAIN;
                            drain <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!mode) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (drain) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsc_tdc_avg.sv
// Self-checking bench for hsc_tdc_avg: stream vector table plus scripted averaging runs.
module tb_hsc_tdc_avg;

    logic         clk_launch;
    logic         rst_n;
    logic [127:0] taps_in;
    logic         val_in;
    logic         ch_sel;
    logic         mode;
    logic         start;
    logic [6:0]   hw;
    logic         val_out;
    logic [6:0]   hw_min;
    logic [6:0]   hw_max;
    logic [10:0]  acc;
    logic         busy;
    logic         done;

    hsc_tdc_avg #(.TAPS(64), .NCH(2), .LOG2_N(4)) dut (
        .clk_launch (clk_launch),
        .rst_n      (rst_n),
        .taps_in    (taps_in),
        .val_in     (val_in),
        .ch_sel     (ch_sel),
        .mode       (mode),
        .start      (start),
        .hw         (hw),
        .val_out    (val_out),
        .hw_min     (hw_min),
        .hw_max     (hw_max),
        .acc        (acc),
        .busy       (busy),
        .done       (done)
    );

    initial clk_launch = 1'b0;
    always #5 clk_launch = ~clk_launch;

    typedef struct {
        logic [63:0] c0;
        logic [63:0] c1;
        logic        sel;
        int          exp_hw;
    } vec_t;

    typedef struct {
        int hw;
        int cyc;
    } str_exp_t;

    typedef struct {
        int acc;
        int hw;
        int mn;
        int mx;
    } avg_exp_t;

    vec_t     tv[8];
    str_exp_t sq[$];
    avg_exp_t aq[$];
    int       wv[16];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;

    function automatic logic [63:0] ones(input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every cycle advance also drains the stream scoreboard.
    task automatic tick();
        str_exp_t e;
        @(posedge clk_launch);
        #1;
        cyc++;
        if (val_out) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL val_out_unexpected: got 1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sq.pop_front();
                if (int'(hw) != e.hw || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL stream_out: got hw=%0d at cycle %0d, expected hw=%0d at cycle %0d",
                             hw, cyc, e.hw, e.cyc);
                end
            end
        end
    endtask

    task automatic sample(input int w0, input int w1);
        taps_in = {ones(w1), ones(w0)};
        val_in  = 1'b1;
        tick();
        val_in  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_run();
        avg_exp_t e;
        e.acc = 0;
        e.mn  = 64;
        e.mx  = 0;
        for (int i = 0; i < 16; i++) begin
            e.acc += wv[i];
            if (wv[i] < e.mn) e.mn = wv[i];
            if (wv[i] > e.mx) e.mx = wv[i];
        end
        e.hw = e.acc / 16;
        aq.push_back(e);
    endtask

    task automatic check_run(input string name);
        avg_exp_t e;
        for (int i = 0; i < 40 && !done; i++) tick();
        e = aq.pop_front();
        check({name, "_done"}, int'(done), 1);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_acc"}, int'(acc), e.acc);
        check({name, "_hw"}, int'(hw), e.hw);
        check({name, "_min"}, int'(hw_min), e.mn);
        check({name, "_max"}, int'(hw_max), e.mx);
    endtask

    initial begin
        tv[0] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32};
        tv[1] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64};
        tv[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b0, 1};
        tv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, 2};
        tv[4] = '{64'h0F0F_0F0F_0F0F_0F0F, 64'h0000_0000_0000_0000, 1'b0, 32};
        tv[5] = '{64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0000, 1'b1, 0};
        tv[6] = '{64'h8000_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0, 1};
        tv[7] = '{64'h0000_0000_0000_0000, 64'h0000_FFFF_0000_0000, 1'b1, 16};

        rst_n   = 1'b0;
        taps_in = '0;
        val_in  = 1'b0;
        ch_sel  = 1'b0;
        mode    = 1'b0;
        start   = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_val_out", int'(val_out), 0);
        check("rst_hw", int'(hw), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_hw_max", int'(hw_max), 0);
        check("rst_hw_min", int'(hw_min), 64);
        rst_n = 1'b1;
        tick();

        // Stream mode: back-to-back samples, start held high must be ignored.
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            taps_in = {tv[i].c1, tv[i].c0};
            ch_sel  = tv[i].sel;
            val_in  = 1'b1;
            sq.push_back('{tv[i].exp_hw, cyc + 2});
            tick();
        end
        val_in = 1'b0;
        start  = 1'b0;
        tick();
        tick();
        tick();
        check("stream_drained", sq.size(), 0);
        check("stream_start_ignored", int'(busy), 0);

        // Alternating weights 10/12.
        mode   = 1'b1;
        ch_sel = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            wv[i] = (i % 2 == 1) ? 12 : 10;
            sample(wv[i], 40);
            if (i == 4) begin
                check("run_a_busy_mid", int'(busy), 1);
                check("run_a_done_mid", int'(done), 0);
            end
        end
        push_run();
        check_run("run_a");

        // All-ones: maximum sum must not overflow.
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            wv[i] = 64;
            sample(64, 0);
        end
        push_run();
        check_run("run_b");

        // Start while busy plus surplus samples must not disturb the run.
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            wv[i] = 5;
            if (i == 8) start = 1'b1;
            sample(5, 50);
            start = 1'b0;
        end
        sample(64, 64);
        sample(64, 64);
        sample(64, 64);
        push_run();
        check_run("run_c");

        // Reset mid-run, then start in the very first cycle afterwards.
        pulse_start();
        for (int i = 0; i < 8; i++) sample(30, 30);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_acc", int'(acc), 0);
        check("midrst_hw_min", int'(hw_min), 64);
        check("midrst_hw_max", int'(hw_max), 0);
        rst_n = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            wv[i] = i;
            sample(i, 63 - i);
        end
        push_run();
        check_run("run_d");

        // Channel latched at start; live ch_sel change mid-run has no effect.
        ch_sel = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) ch_sel = 1'b0;
            wv[i] = 20;
            sample(3, 20);
        end
        push_run();
        check_run("run_e");

        // Abort by leaving average mode, then re-enter without starting.
        pulse_start();
        for (int i = 0; i < 4; i++) sample(7, 7);
        check("abort_busy_before", int'(busy), 1);
        mode = 1'b0;
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        mode = 1'b1;
        tick();
        tick();
        check("abort_stay_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
